lighthouse_sensor_arbiter: RTL and testbench
============================================

// Module: lighthouse_sensor_arbiter
// PURPOSE
//  Shares one Avalon-MM readout path among NUM_SENSORS lighthouse_sensor instances.
//  Captures each sensor's ready pulse and combined_data into a one-deep holding register.
//  Schedules holding registers round-robin into a result FIFO.
//  The HPS drains the FIFO word by word over Avalon. Sits between the sensor array and the Avalon fabric.
// PARAMETERS
//  NUM_SENSORS  16  number of sensor channels (2..32)
//  FIFO_DEPTH   32  result FIFO entries; power of 2
//  ID_W         4   sensor id width = clog2(NUM_SENSORS)
// PORTS
//  clock          in   1               system clock
//  reset          in   1               asynchronous, active-high
//  address        in   3               Avalon word address
//  write          in   1               Avalon write strobe
//  writedata      in   32              Avalon write data
//  read           in   1               Avalon read strobe
//  readdata       out  32              Avalon read data, combinational on address
//  waitrequest    out  1               tied 0: zero-wait slave
//  sensor_ready   in   NUM_SENSORS     per-sensor 1-cycle result pulse
//  sensor_data    in   32*NUM_SENSORS  per-sensor combined_data; sensor i at [32i+31:32i]
//  data_available out  1               registered !fifo_empty; reset 0
// BEHAVIOUR
//  Reset: holding regs invalid, FIFO empty, drop_count 0, enable_mask all 1, rr pointer = NUM_SENSORS-1, data_available 0.
//  Capture, sensor i, each cycle: if sensor_ready[i] && enable_mask[i], load hold_data[i] and set hold_valid[i].
//   If hold_valid[i] is already set and i is not granted that cycle: overwrite and increment drop_count (16 b, saturating at 16'hFFFF).
//   If i is granted in the same cycle: the grant takes the old value, the new value is loaded, and no drop is counted.
//  Mask clear: enable_mask[i]=0 clears hold_valid[i] on the next edge. No drop is counted.
//  Arbitration: at most 1 grant per cycle.
//   Grant when (count < FIFO_DEPTH || pop this cycle) and some hold_valid is set and no flush is active.
//   Winner: first valid index searching upward from rr+1, wrapping mod NUM_SENSORS; rr <= winner.
//   Grant pushes {id, hold_data} and clears hold_valid[winner] at the same edge. Capture-to-FIFO latency is 2 edges minimum.
//  FIFO: count width clog2(FIFO_DEPTH)+1. Push and pop in the same cycle leave count unchanged, including when full.
//   Pointers wrap modulo FIFO_DEPTH.
//  Register map (readdata):
//   0 R   {drop_count[15:0], count zero-extended to 16}
//   1 R   head data; read while !empty pops at the clock edge. Read while empty returns 32'hDEAD_BEEF and does not pop.
//   2 R   head sensor id zero-extended, no pop; empty returns 32'hDEAD_BEEF
//   3 R/W enable_mask in low NUM_SENSORS bits; upper bits read 0
//   4 W   bit0=1 flushes the FIFO (count 0); bit1=1 clears drop_count. Reads return 32'hDEAD_BEEF.
//   5-7   read 32'hDEAD_BEEF; writes ignored
//  Flush cycle: flush wins over push and pop; no grant that cycle; holding regs keep their values.
//  Clear drop_count and a simultaneous drop in the same cycle: result is 0.
//  Reset mid-operation: all state returns to reset values immediately; in-flight entries are lost.
// STRUCTURE
//  Shared package lighthouse_pkg: SENSOR_DATA_W=32, register address localparams (REG_STATUS..REG_CTRL), DEAD_BEEF constant.
//  One sub-module, lh_result_fifo: synchronous FIFO (push, pop, flush, count, full, empty) with width ID_W+32.
//  Holding registers, round-robin arbiter and Avalon decode stay in this module.
// TESTING
//  1 Reset, then pulse sensor 3 with 32'h1234_5678 -> after 2 edges reg0 = 32'h0000_0001, reg2 = 3; reading reg1 returns 32'h1234_5678, then reg0 = 0.
//  2 Pulse sensors 0, 5 and 9 in the same cycle, rr=NUM_SENSORS-1 -> FIFO order ids 0, 5, 9.
//    Next pulse of 0 and 5 with rr=9 -> order 0, 5.
//  3 Pulse sensor 2 twice in consecutive cycles while the FIFO is full -> drop_count=1 and holding reg keeps the second value.
//    Pop once -> second value enters the FIFO.
//  4 Fill the FIFO to 32 entries and issue a simultaneous pop and pending grant -> count stays 32 with correct order. Read reg1 on empty -> 32'hDEAD_BEEF and count stays 0.
//  5 Write reg3=32'h0000_FFFE, then pulse sensor 0 -> nothing captured.
//    Write reg4=3 with 5 entries queued -> count 0 and drop_count 0.
//  6 Assert reset mid-drain with 10 entries queued -> data_available=0, reg0=0, reg3=32'h0000_FFFF.

Source files
------------

// File: rtl/lighthouse_pkg.sv
// Shared constants for the lighthouse sensor readout path.
// Register map, data width and the empty-read marker.
package lighthouse_pkg;

    localparam int SENSOR_DATA_W = 32;

    typedef logic [2:0] reg_addr_t;

    localparam reg_addr_t REG_STATUS = 3'd0;
    localparam reg_addr_t REG_DATA   = 3'd1;
    localparam reg_addr_t REG_ID     = 3'd2;
    localparam reg_addr_t REG_MASK   = 3'd3;
    localparam reg_addr_t REG_CTRL   = 3'd4;

    localparam logic [31:0] DEAD_BEEF = 32'hDEAD_BEEF;

    function automatic logic [15:0] sat_add16(
        input logic [15:0] a,
        input logic [15:0] b
    );
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

endpackage

// File: rtl/lh_result_fifo.sv
// Synchronous result FIFO with flush; push/pop together keep count.
// Flush has priority over both push and pop.
module lh_result_fifo #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 32
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic                       i_flush,
    input  logic [WIDTH-1:0]           i_wdata,
    output logic [WIDTH-1:0]           o_rdata,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_full,
    output logic                       o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_rdata = r_mem[r_rd_ptr];

    assign w_pop  = i_pop && !o_empty;
    assign w_push = i_push && (!o_full || w_pop);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)
                r_count <= r_count + 1'b1;
            else if (w_pop && !w_push)
                r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (w_push && !i_flush)
            r_mem[r_wr_ptr] <= i_wdata;
    end

endmodule

// File: rtl/lighthouse_sensor_arbiter.sv
// Captures sensor results into holding registers and schedules them
// round-robin into a result FIFO drained over a zero-wait Avalon slave.
module lighthouse_sensor_arbiter
    import lighthouse_pkg::*;
#(
    parameter int NUM_SENSORS = 16,
    parameter int FIFO_DEPTH  = 32,
    parameter int ID_W        = 4
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic [2:0]                          address,
    input  logic                                write,
    input  logic [31:0]                         writedata,
    input  logic                                read,
    output logic [31:0]                         readdata,
    output logic                                waitrequest,
    input  logic [NUM_SENSORS-1:0]              sensor_ready,
    input  logic [SENSOR_DATA_W*NUM_SENSORS-1:0] sensor_data,
    output logic                                data_available
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int EW = ID_W + SENSOR_DATA_W;

    logic [NUM_SENSORS-1:0]   r_hold_valid;
    logic [SENSOR_DATA_W-1:0] r_hold_data [NUM_SENSORS];
    logic [NUM_SENSORS-1:0]   r_enable_mask;
    logic [15:0]              r_drop_count;
    logic [ID_W-1:0]          r_rr;
    logic                     r_data_available;

    logic                     w_pop;
    logic                     w_flush;
    logic                     w_clr_drop;
    logic                     w_mask_wr;
    logic                     w_found;
    logic                     w_grant;
    logic [ID_W-1:0]          w_winner;
    logic [NUM_SENSORS-1:0]   w_drop;
    logic [15:0]              w_drop_n;
    logic [EW-1:0]            w_push_data;
    logic [EW-1:0]            w_head;
    logic [CW-1:0]            w_count;
    logic                     w_full;
    logic                     w_empty;
    logic                     w_unused_wd;

    assign waitrequest    = 1'b0;
    assign data_available = r_data_available;
    assign w_unused_wd    = ^writedata;

    assign w_pop      = read && (address == REG_DATA) && !w_empty;
    assign w_flush    = write && (address == REG_CTRL) && writedata[0];
    assign w_clr_drop = write && (address == REG_CTRL) && writedata[1];
    assign w_mask_wr  = write && (address == REG_MASK);

    // Search upward from the last winner, wrapping at NUM_SENSORS.
    always_comb begin : arb
        int t;
        t        = 0;
        w_found  = 1'b0;
        w_winner = r_rr;
        for (int k = 1; k <= NUM_SENSORS; k++) begin
            t = int'(r_rr) + k;
            if (t >= NUM_SENSORS) t = t - NUM_SENSORS;
            if (!w_found && r_hold_valid[ID_W'(t)]) begin
                w_found  = 1'b1;
                w_winner = ID_W'(t);
            end
        end
    end

    assign w_grant = w_found && !w_flush && (!w_full || w_pop);
    assign w_push_data = {w_winner, r_hold_data[w_winner]};

    always_comb begin
        w_drop = '0;
        for (int i = 0; i < NUM_SENSORS; i++) begin
            w_drop[i] = r_enable_mask[i] && sensor_ready[i] &&
                        r_hold_valid[i] &&
                        !(w_grant && (w_winner == ID_W'(i)));
        end
    end

    assign w_drop_n = 16'($countones(w_drop));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_hold_valid <= '0;
            for (int i = 0; i < NUM_SENSORS; i++)
                r_hold_data[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_SENSORS; i++) begin
                if (!r_enable_mask[i]) begin
                    r_hold_valid[i] <= 1'b0;
                end else if (sensor_ready[i]) begin
                    r_hold_data[i]  <= sensor_data[SENSOR_DATA_W*i +: SENSOR_DATA_W];
                    r_hold_valid[i] <= 1'b1;
                end else if (w_grant && (w_winner == ID_W'(i))) begin
                    r_hold_valid[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_drop_count     <= '0;
            r_enable_mask    <= '1;
            r_rr             <= ID_W'(NUM_SENSORS - 1);
            r_data_available <= 1'b0;
        end else begin
            if (w_clr_drop)
                r_drop_count <= '0;
            else
                r_drop_count <= sat_add16(r_drop_count, w_drop_n);
            if (w_mask_wr)
                r_enable_mask <= writedata[NUM_SENSORS-1:0];
            if (w_grant)
                r_rr <= w_winner;
            r_data_available <= !w_empty;
        end
    end

    lh_result_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .i_push  (w_grant),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .i_wdata (w_push_data),
        .o_rdata (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_comb begin
        readdata = DEAD_BEEF;
        unique case (1'b1)
            address == REG_STATUS:
                readdata = {r_drop_count, 16'(w_count)};
            address == REG_DATA:
                readdata = w_empty ? DEAD_BEEF : w_head[SENSOR_DATA_W-1:0];
            address == REG_ID:
                readdata = w_empty ? DEAD_BEEF : 32'(w_head[EW-1:SENSOR_DATA_W]);
            address == REG_MASK:
                readdata = 32'(r_enable_mask);
            default:
                readdata = DEAD_BEEF;
        endcase
    end

endmodule

// File: tb/tb_lighthouse_sensor_arbiter.sv
// Randomized and directed bench for lighthouse_sensor_arbiter with a
// queue-based reference model checked on every cycle.
module tb_lighthouse_sensor_arbiter;

    localparam int N = 16;
    localparam int D = 32;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic [2:0]      address = '0;
    logic            write = 1'b0;
    logic            read = 1'b0;
    logic [31:0]     writedata = '0;
    logic [31:0]     readdata;
    logic            waitrequest;
    logic [N-1:0]    sensor_ready = '0;
    logic [32*N-1:0] sensor_data;
    logic            data_available;
    logic [31:0]     sdat [N];

    always #5 clock = ~clock;

    always_comb begin
        sensor_data = '0;
        for (int i = 0; i < N; i++)
            sensor_data[32*i +: 32] = sdat[i];
    end

    lighthouse_sensor_arbiter #(
        .NUM_SENSORS (N),
        .FIFO_DEPTH  (D),
        .ID_W        (4)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .address        (address),
        .write          (write),
        .writedata      (writedata),
        .read           (read),
        .readdata       (readdata),
        .waitrequest    (waitrequest),
        .sensor_ready   (sensor_ready),
        .sensor_data    (sensor_data),
        .data_available (data_available)
    );

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] d;
    } ent_t;

    int          checks = 0;
    int          errors = 0;
    ent_t        q[$];
    logic [N-1:0] mv;
    logic [31:0] md [N];
    logic [15:0] mmask;
    int          mdrop;
    int          mrr;
    logic        da_exp;
    logic [31:0] last_rd;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        q.delete();
        mv = '0;
        for (int i = 0; i < N; i++) md[i] = '0;
        mmask  = '1;
        mdrop  = 0;
        mrr    = N - 1;
        da_exp = 1'b0;
    endfunction

    function automatic logic [31:0] exp_rd(input logic [2:0] a);
        case (a)
            3'd0: return {16'(mdrop), 16'(q.size())};
            3'd1: return (q.size() > 0) ? q[0].d : 32'hDEAD_BEEF;
            3'd2: return (q.size() > 0) ? 32'(q[0].id) : 32'hDEAD_BEEF;
            3'd3: return 32'(mmask);
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    function automatic void model_edge(input logic [2:0] a, input logic w,
                                       input logic [31:0] wd, input logic r,
                                       input logic [N-1:0] rdy);
        int   sz;
        int   win;
        int   ndrop;
        int   j;
        bit   pop;
        bit   flush;
        bit   clr;
        ent_t e;
        sz    = q.size();
        pop   = r && (a == 3'd1) && (sz > 0);
        flush = w && (a == 3'd4) && wd[0];
        clr   = w && (a == 3'd4) && wd[1];
        win   = -1;
        ndrop = 0;
        if (!flush && (sz < D || pop)) begin
            for (int k = 1; k <= N; k++) begin
                j = (mrr + k) % N;
                if (win < 0 && mv[j]) win = j;
            end
        end
        if (flush) begin
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (win >= 0) begin
                e.id = 4'(win);
                e.d  = md[win];
                q.push_back(e);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!mmask[i]) begin
                mv[i] = 1'b0;
            end else if (rdy[i]) begin
                if (mv[i] && win != i) ndrop++;
                md[i] = sdat[i];
                mv[i] = 1'b1;
            end else if (win == i) begin
                mv[i] = 1'b0;
            end
        end
        if (clr) mdrop = 0;
        else mdrop = (mdrop + ndrop > 65535) ? 65535 : mdrop + ndrop;
        if (w && a == 3'd3) mmask = wd[15:0];
        if (win >= 0) mrr = win;
        da_exp = (sz > 0);
    endfunction

    // Inputs change just after the falling edge; outputs sampled 1 ns later.
    task automatic step(input logic [2:0] a, input logic w,
                        input logic [31:0] wd, input logic r,
                        input logic [N-1:0] rdy);
        address      = a;
        write        = w;
        writedata    = wd;
        read         = r;
        sensor_ready = rdy;
        #1;
        last_rd = readdata;
        chk("readdata", readdata, exp_rd(a));
        chk("data_available", 32'(data_available), 32'(da_exp));
        chk("waitrequest", 32'(waitrequest), 32'd0);
        @(posedge clock);
        model_edge(a, w, wd, r, rdy);
        @(negedge clock);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(3'd0, 1'b0, 32'd0, 1'b0, '0);
    endtask

    task automatic rd(input logic [2:0] a);
        step(a, 1'b0, 32'd0, 1'b1, '0);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] v);
        step(a, 1'b1, v, 1'b0, '0);
    endtask

    task automatic do_reset();
        address = '0; write = 1'b0; read = 1'b0; sensor_ready = '0;
        reset = 1'b1;
        model_reset();
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic fill32();
        for (int k = 0; k < D; k++) begin
            sdat[k % N] = 32'hF000_0000 | 32'(k);
            step(3'd0, 1'b0, 32'd0, 1'b0, N'(1) << (k % N));
        end
        idle(2);
    endtask

    initial begin
        int ctl;
        logic [2:0] a;
        for (int i = 0; i < N; i++) sdat[i] = '0;
        do_reset();

        // Single capture, two-edge latency, readback and pop.
        sdat[3] = 32'h1234_5678;
        step(3'd0, 1'b0, 32'd0, 1'b0, 16'h0008);
        idle(1);
        step(3'd0, 1'b0, 32'd0, 1'b0, '0);
        chk("t1_reg0", last_rd, 32'h0000_0001);
        rd(3'd2);
        chk("t1_reg2", last_rd, 32'd3);
        rd(3'd1);
        chk("t1_reg1", last_rd, 32'h1234_5678);
        rd(3'd0);
        chk("t1_reg0_after", last_rd, 32'h0000_0000);

        // Round-robin order.
        do_reset();
        sdat[0] = 32'hA000_0000; sdat[5] = 32'hA000_0005; sdat[9] = 32'hA000_0009;
        step(3'd0, 1'b0, 32'd0, 1'b0, 16'h0221);
        idle(4);
        rd(3'd2); chk("t2_id0", last_rd, 32'd0); rd(3'd1);
        rd(3'd2); chk("t2_id1", last_rd, 32'd5); rd(3'd1);
        rd(3'd2); chk("t2_id2", last_rd, 32'd9); rd(3'd1);
        step(3'd0, 1'b0, 32'd0, 1'b0, 16'h0021);
        idle(3);
        rd(3'd2); chk("t2_id3", last_rd, 32'd0); rd(3'd1);
        rd(3'd2); chk("t2_id4", last_rd, 32'd5); rd(3'd1);

        // Drop while full, then pop with a pending grant.
        fill32();
        rd(3'd0); chk("t3_full", last_rd, 32'h0000_0020);
        sdat[2] = 32'hBBBB_0001;
        step(3'd0, 1'b0, 32'd0, 1'b0, 16'h0004);
        sdat[2] = 32'hBBBB_0002;
        step(3'd0, 1'b0, 32'd0, 1'b0, 16'h0004);
        idle(1);
        rd(3'd0); chk("t3_drop", last_rd, 32'h0001_0020);
        rd(3'd1);
        rd(3'd0); chk("t4_popgrant", last_rd, 32'h0001_0020);
        for (int k = 0; k < D; k++) rd(3'd1);
        chk("t3_last", last_rd, 32'hBBBB_0002);
        rd(3'd1); chk("t4_empty", last_rd, 32'hDEAD_BEEF);
        rd(3'd0); chk("t4_cnt0", last_rd, 32'h0001_0000);

        // Masking and control register.
        wr(3'd3, 32'h0000_FFFE);
        sdat[0] = 32'hC0C0_C0C0;
        step(3'd0, 1'b0, 32'd0, 1'b0, 16'h0001);
        idle(2);
        rd(3'd0); chk("t5_masked", last_rd, 32'h0001_0000);
        wr(3'd3, 32'h0000_FFFF);
        step(3'd0, 1'b0, 32'd0, 1'b0, 16'h003E);
        idle(6);
        rd(3'd0); chk("t5_five", last_rd, 32'h0001_0005);
        wr(3'd4, 32'd3);
        rd(3'd0); chk("t5_ctrl", last_rd, 32'h0000_0000);
        rd(3'd4); chk("t5_reg4", last_rd, 32'hDEAD_BEEF);

        // Drop counter saturation, then clear racing further drops.
        fill32();
        for (int k = 0; k < 4200; k++) begin
            for (int i = 0; i < N; i++) sdat[i] = $urandom;
            step(3'd0, 1'b0, 32'd0, 1'b0, '1);
        end
        rd(3'd0); chk("sat", last_rd, 32'hFFFF_0020);
        step(3'd4, 1'b1, 32'd2, 1'b0, '1);
        rd(3'd0); chk("clr_race", last_rd, 32'h0000_0020);
        wr(3'd4, 32'd1);
        idle(3);

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) sdat[i] = $urandom;
            ctl = $urandom_range(0, 99);
            a = 3'($urandom_range(0, 7));
            if (ctl < 45)
                step((ctl < 30) ? 3'd1 : a, 1'b0, 32'd0, 1'b1,
                     N'($urandom & $urandom & $urandom));
            else if (ctl < 49)
                step(3'd3, 1'b1, $urandom | 32'h0000_F0F0, 1'b0,
                     N'($urandom & $urandom));
            else if (ctl < 51)
                step(3'd4, 1'b1, 32'($urandom_range(0, 3)), 1'b0,
                     N'($urandom & $urandom));
            else
                step(a, 1'b0, $urandom, 1'b0,
                     N'($urandom & $urandom & $urandom));
        end

        // Reset in the middle of a drain.
        do_reset();
        for (int i = 0; i < N; i++) sdat[i] = 32'h5000_0000 | 32'(i);
        step(3'd0, 1'b0, 32'd0, 1'b0, 16'h03FF);
        idle(12);
        rd(3'd1);
        rd(3'd1);
        address = 3'd0; read = 1'b0; write = 1'b0; sensor_ready = '0;
        reset = 1'b1;
        #1;
        chk("t6_da", 32'(data_available), 32'd0);
        chk("t6_reg0", readdata, 32'h0000_0000);
        address = 3'd3;
        #1;
        chk("t6_reg3", readdata, 32'h0000_FFFF);
        model_reset();
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        idle(3);
        rd(3'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
